gpio_link_rx: RTL

Receive end of the inter-board GPIO button link; the partner board drives the link from its mouse buttons.
- Takes raw asynchronous gpio_left_in / gpio_right_in pins.
- Synchronises and debounces each channel independently.
- Outputs clean button levels plus one-cycle press/release pulses.
- Outputs feed the player-2 movement controller and the game state controller in place of raw pin reads.

---
 rtl/gpio_link_rx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/gpio_link_rx.sv
// Receive end of the inter-board GPIO button link.
// Each of the two raw pins (left, right) is synchronised and debounced on its own;
// the block presents clean levels, one-cycle press/release pulses and a combined 'both'.
// Optional stuck-high detection is built when GPIO_LINK_RX_STUCK_DET_EN is defined;
// without it the stuck flags are tied to zero.
module gpio_link_rx #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 65000,
   parameter int unsigned CNT_W           = 17,
   parameter int unsigned STUCK_CYCLES    = 650000000,
   parameter int unsigned STUCK_W         = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       gpio_left_in,
   input  logic       gpio_right_in,
   output logic       left,
   output logic       right,
   output logic       left_rise,
   output logic       left_fall,
   output logic       right_rise,
   output logic       right_fall,
   output logic       both,
   output logic [1:0] stuck
);

   typedef enum logic [1:0] {IdleLow, ChkHigh, IdleHigh, ChkLow} state_e;

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0] pin;
   logic [1:0] level;
   logic [1:0] rise;
   logic [1:0] fall;
   logic [1:0] stuck_flag;

   // Channel 0 is left, channel 1 is right.
   assign pin = {gpio_right_in, gpio_left_in};

   for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      state_e                 state_q, state_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   level_q, level_d;
      logic                   rise_q, rise_d;
      logic                   fall_q, fall_d;
      logic                   accept;
      logic                   stuck_hit;
      logic                   stuck_q;

      // Synchroniser shift register; the pin enters stage 0 every edge.
      always_ff @(posedge clk) begin
         if (!rst) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin[ch]};
         end
      end

      assign s      = sync_q[SYNC_STAGES-1];
      // Candidate has been stable for the full window once this sample also agrees.
      assign accept = (cnt_q == CntMax);

      // State, counter and registered outputs.
      always_ff @(posedge clk) begin
         if (!rst) begin
            state_q <= IdleLow;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
         end
      end

      // Next-state and debounce counter.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         unique case (state_q)
            IdleLow: begin
               if (s) begin
                  state_d = ChkHigh;
                  cnt_d   = CNT_W'(1);
               end
            end
            ChkHigh: begin
               if (!s) begin
                  state_d = IdleLow;
                  cnt_d   = '0;
               end else if (accept) begin
                  state_d = IdleHigh;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            IdleHigh: begin
               if (!s) begin
                  state_d = ChkLow;
                  cnt_d   = CNT_W'(1);
               end
            end
            ChkLow: begin
               if (s) begin
                  state_d = IdleHigh;
                  cnt_d   = '0;
               end else if (accept) begin
                  state_d = IdleLow;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         endcase
      end

      // Level and pulse next values.
      always_comb begin
         level_d = level_q;
         rise_d  = 1'b0;
         fall_d  = 1'b0;
         unique case (state_q)
            ChkHigh: begin
               if (s && accept) begin
                  level_d = 1'b1;
                  rise_d  = 1'b1;
               end
            end
            IdleHigh: begin
               if (stuck_hit) begin
                  level_d = 1'b0;
                  fall_d  = 1'b1;
               end
            end
            ChkLow: begin
               if (!s && accept) begin
                  level_d = 1'b0;
                  // A stuck channel already dropped its level and pulsed once.
                  fall_d  = level_q;
               end
            end
            default: ;
         endcase
      end

`ifdef GPIO_LINK_RX_STUCK_DET_EN
      localparam logic [STUCK_W-1:0] StuckMax = STUCK_W'(STUCK_CYCLES - 1);

      logic [STUCK_W-1:0] scnt_q, scnt_d;
      logic               stuck_d;

      assign stuck_hit = (state_q == IdleHigh) && (scnt_q == StuckMax) && !stuck_q;

      // Stuck counter runs only while resting in IdleHigh and freezes at its limit.
      always_comb begin
         scnt_d  = '0;
         stuck_d = stuck_q;
         if (state_q == IdleHigh && state_d == IdleHigh) begin
            scnt_d = (scnt_q == StuckMax) ? scnt_q : scnt_q + 1'b1;
         end
         if (stuck_hit) begin
            stuck_d = 1'b1;
         end else if (state_q == ChkLow && !s && accept) begin
            stuck_d = 1'b0;
         end
      end

      // Stuck counter and flag registers.
      always_ff @(posedge clk) begin
         if (!rst) begin
            scnt_q  <= '0;
            stuck_q <= 1'b0;
         end else begin
            scnt_q  <= scnt_d;
            stuck_q <= stuck_d;
         end
      end
`else
      assign stuck_hit = 1'b0;
      assign stuck_q   = 1'b0;
`endif

      assign level[ch]      = level_q;
      assign rise[ch]       = rise_q;
      assign fall[ch]       = fall_q;
      assign stuck_flag[ch] = stuck_q;
   end

`ifndef GPIO_LINK_RX_STUCK_DET_EN
   logic unused_stuck_cfg;
   assign unused_stuck_cfg = ^(STUCK_W'(STUCK_CYCLES));
`endif

   assign left       = level[0];
   assign right      = level[1];
   assign left_rise  = rise[0];
   assign left_fall  = fall[0];
   assign right_rise = rise[1];
   assign right_fall = fall[1];
   assign both       = level[0] & level[1];
   assign stuck      = stuck_flag;

endmodule
